dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and sequencer in front of the single-port 32-bit data memory. Two requesters share one memory: port 0 is the CPU load/store unit and port 1 is a debug/DMA loader. Each access is serialized through a small state machine with round-robin fairness. Each access is checked against the legal data window, and writes outside the window are suppressed. The block sits between the requesters and the memory's address, write-data, write-enable and read-data pins.

## Interface
Parameters:
- P_BASE, 32'h7FFFFF00, lowest legal word address (inclusive)
- P_TOP, 32'h7FFFFFFC, highest legal word address (inclusive)

Ports:
- i_CLK  in  1  clock; all state changes on its rising edge
- i_RST  in  1  reset, synchronous, active-high
- i_req0 / i_req1  in  1  access request, held until the matching o_done pulse
- i_we0 / i_we1  in  1  1 = write, 0 = read; stable while request is high
- i_a0 / i_a1  in  32  byte address; stable while request is high
- i_wd0 / i_wd1  in  32  write data; stable while request is high
- o_done0 / o_done1  out  1  one-cycle completion pulse
- o_rd0 / o_rd1  out  32  read data, valid while the matching o_done is high; holds until next completion on that port
- o_err0 / o_err1  out  1  high with o_done when the access was rejected
- o_busy  out  1  high in ACCESS and RESP
- o_mem_a  out  32  memory address
- o_mem_wd  out  32  memory write data
- o_mem_we  out  1  memory write enable
- i_mem_rd  in  32  memory read data, combinational from o_mem_a

## Operation
- States: IDLE, ACCESS, RESP. A 1-bit owner register records the port being served. A 1-bit priority pointer records which port wins a tie.
- IDLE: if any request is high, pick the winner and latch its we/a/wd into internal registers.
  - Only one request high: that port wins.
  - Both high: the port named by the pointer wins.
  - Then go to ACCESS. With no request, stay in IDLE.
- ACCESS: drive o_mem_a/o_mem_wd from the latched values.
  - o_mem_we = latched_we AND legal AND NOT i_RST.
  - At the closing edge:
    - a legal read captures i_mem_rd into o_rd[owner];
    - a write leaves o_rd[owner] unchanged;
    - an illegal access loads 0 into o_rd[owner].
  - Then go to RESP.
- RESP: o_done[owner] = 1 and o_err[owner] = the rejection flag. The pointer flips to the non-owner.
  - If the non-owner's request is high, latch it and go directly to ACCESS (back-to-back service).
  - Otherwise go to IDLE.
  - The owner's request is ignored in RESP, so an unchanged request is never served twice.
- Legal means address[1:0] == 0 and P_BASE <= address <= P_TOP (unsigned compare, 32-bit, no wrap).
- o_mem_we is 0 in IDLE and RESP. o_mem_a and o_mem_wd hold their last latched values outside ACCESS.

## Timing
- Reset values:
  - state = IDLE, owner = 0, pointer = 0 (port 0 favored);
  - o_done* = 0, o_err* = 0, o_rd* = 0, o_busy = 0;
  - o_mem_a = 0, o_mem_wd = 0, o_mem_we = 0.
- Latency: a request sampled high at edge k (in IDLE) gives ACCESS in cycle k..k+1 and o_done high in cycle k+1..k+2. The write to memory lands at edge k+1.
- Throughput: one access per 2 cycles with alternating requesters; one per 3 cycles when a single requester streams.
- Reset asserted while in ACCESS: no memory write occurs at that edge, and no o_done is produced for the aborted access.
- A request dropped before o_done: if the access is already latched, it still completes.
- Simultaneous first requests after reset go to port 0 first.

## Configuration
- DMEM_ARB_RANGE_CHECK_EN defined: legality checking as above, and o_err can assert.
- Not defined: every access is legal, o_err0/o_err1 are tied 0, and P_BASE/P_TOP are unused.

## Structure
- Package dmem_arb_pkg holds:
  - the state enum (IDLE, ACCESS, RESP);
  - default window constants DMEM_BASE/DMEM_TOP;
  - port index constants.
- One sub-module, rr_arb2: a combinational two-way round-robin picker. Inputs are the two request bits and the pointer; outputs are a grant-valid bit and the winner index.

## Test plan
- Reset, then port 0 writes 0x113 to 0x7FFFFF10 and later reads it back:
  - o_mem_we high for exactly one cycle;
  - read gives o_done0 with o_rd0 = 0x00000113 and o_err0 = 0.
- Both ports request in the same cycle right after reset:
  - port 0 is served first;
  - port 1 is served immediately after (RESP goes to ACCESS) with no IDLE gap;
  - the next tie goes to port 0 again.
- Port 1 writes 0x1869F to address 0x0, illegal with the macro defined:
  - o_mem_we never asserts;
  - o_done1 and o_err1 high, o_rd1 = 0.
- Port 0 writes to 0x7FFFFF11 (misaligned): rejected with o_err0. With the macro undefined, the same stimulus asserts o_mem_we and o_err0 = 0.
- Assert i_RST during ACCESS of a write to 0x7FFFFF20:
  - no write occurs (a subsequent read returns the prior value);
  - no o_done pulse;
  - all outputs return to reset values.
- Port 0 holds i_req0 high continuously:
  - one o_done0 every 3 cycles;
  - when port 1 raises a request, port 1 is served next.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_t;

    localparam logic [31:0] DMEM_BASE = 32'h7FFF_FF00;
    localparam logic [31:0] DMEM_TOP  = 32'h7FFF_FFFC;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    function automatic logic addr_legal(
        input logic [31:0] a,
        input logic [31:0] base,
        input logic [31:0] top
    );
        return (a[1:0] == 2'b00) && (a >= base) && (a <= top);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin picker
module rr_arb2 (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_ptr,
    output logic o_valid,
    output logic o_idx
);

    // a lone requester always wins; on a tie the pointer names the winner
    always_comb begin
        o_valid = i_req0 | i_req1;
        if (i_req0 && i_req1) begin
            o_idx = i_ptr;
        end else begin
            o_idx = i_req1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin sequencer for the data memory (option: DMEM_ARB_RANGE_CHECK_EN)
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter logic [31:0] P_BASE = DMEM_BASE,
    parameter logic [31:0] P_TOP  = DMEM_TOP
) (
    input  logic        i_CLK,
    input  logic        i_RST,
    input  logic        i_req0,
    input  logic        i_req1,
    input  logic        i_we0,
    input  logic        i_we1,
    input  logic [31:0] i_a0,
    input  logic [31:0] i_a1,
    input  logic [31:0] i_wd0,
    input  logic [31:0] i_wd1,
    output logic        o_done0,
    output logic        o_done1,
    output logic [31:0] o_rd0,
    output logic [31:0] o_rd1,
    output logic        o_err0,
    output logic        o_err1,
    output logic        o_busy,
    output logic [31:0] o_mem_a,
    output logic [31:0] o_mem_wd,
    output logic        o_mem_we,
    input  logic [31:0] i_mem_rd
);

    arb_state_t  r_state;
    arb_state_t  w_state_nxt;

    logic        r_owner;
    logic        r_ptr;
    logic        r_we;
    logic [31:0] r_a;
    logic [31:0] r_wd;
    logic [31:0] r_rd0;
    logic [31:0] r_rd1;
    logic        r_err;

    logic        w_gnt_valid;
    logic        w_gnt_idx;
    logic        w_load;
    logic        w_ld_idx;
    logic        w_ptr_nxt;
    logic        w_other_req;
    logic        w_legal;
    logic        w_err;
    logic        w_ld_we;
    logic [31:0] w_ld_a;
    logic [31:0] w_ld_wd;

    rr_arb2 u_rr_arb2 (
        .i_req0  (i_req0),
        .i_req1  (i_req1),
        .i_ptr   (r_ptr),
        .o_valid (w_gnt_valid),
        .o_idx   (w_gnt_idx)
    );

`ifdef DMEM_ARB_RANGE_CHECK_EN
    assign w_legal = addr_legal(r_a, P_BASE, P_TOP);
    assign w_err   = r_err;
`else
    logic w_unused_window;
    assign w_legal         = 1'b1;
    assign w_err           = 1'b0;
    assign w_unused_window = ^{P_BASE, P_TOP, r_err};
`endif

    // In RESP only the other port may be picked up, so a held request is not served twice
    assign w_other_req = (r_owner == PORT_CPU) ? i_req1 : i_req0;

    assign w_ld_we = (w_ld_idx == PORT_DBG) ? i_we1 : i_we0;
    assign w_ld_a  = (w_ld_idx == PORT_DBG) ? i_a1  : i_a0;
    assign w_ld_wd = (w_ld_idx == PORT_DBG) ? i_wd1 : i_wd0;

    assign o_rd0    = r_rd0;
    assign o_rd1    = r_rd1;
    assign o_mem_a  = r_a;
    assign o_mem_wd = r_wd;

    // state register
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next-state, request latching and per-state outputs
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_ld_idx    = r_owner;
        w_ptr_nxt   = r_ptr;
        o_done0     = 1'b0;
        o_done1     = 1'b0;
        o_err0      = 1'b0;
        o_err1      = 1'b0;
        o_busy      = 1'b0;
        o_mem_we    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt_valid) begin
                    w_load      = 1'b1;
                    w_ld_idx    = w_gnt_idx;
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                o_busy      = 1'b1;
                // reset in this cycle must keep the write off the memory pins
                o_mem_we    = r_we & w_legal & ~i_RST;
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                o_busy    = 1'b1;
                o_done0   = (r_owner == PORT_CPU);
                o_done1   = (r_owner == PORT_DBG);
                o_err0    = (r_owner == PORT_CPU) & w_err;
                o_err1    = (r_owner == PORT_DBG) & w_err;
                w_ptr_nxt = ~r_owner;
                if (w_other_req) begin
                    w_load      = 1'b1;
                    w_ld_idx    = ~r_owner;
                    w_state_nxt = ST_ACCESS;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // owner/pointer, latched request, and read-data capture at the end of ACCESS
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_owner <= PORT_CPU;
            r_ptr   <= PORT_CPU;
            r_we    <= 1'b0;
            r_a     <= 32'h0;
            r_wd    <= 32'h0;
            r_rd0   <= 32'h0;
            r_rd1   <= 32'h0;
            r_err   <= 1'b0;
        end else begin
            r_ptr <= w_ptr_nxt;
            if (w_load) begin
                r_owner <= w_ld_idx;
                r_we    <= w_ld_we;
                r_a     <= w_ld_a;
                r_wd    <= w_ld_wd;
            end
            if (r_state == ST_ACCESS) begin
                r_err <= ~w_legal;
                if (!w_legal) begin
                    if (r_owner == PORT_DBG) begin
                        r_rd1 <= 32'h0;
                    end else begin
                        r_rd0 <= 32'h0;
                    end
                end else if (!r_we) begin
                    if (r_owner == PORT_DBG) begin
                        r_rd1 <= i_mem_rd;
                    end else begin
                        r_rd0 <= i_mem_rd;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [31:0] a0, a1, wd0, wd1;
    logic        done0, done1, err0, err1, busy, mem_we;
    logic [31:0] rd0, rd1, mem_a, mem_wd, mem_rd;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .P_BASE (32'h7FFF_FF00),
        .P_TOP  (32'h7FFF_FFFC)
    ) dut (
        .i_CLK    (clk),
        .i_RST    (rst),
        .i_req0   (req0),
        .i_req1   (req1),
        .i_we0    (we0),
        .i_we1    (we1),
        .i_a0     (a0),
        .i_a1     (a1),
        .i_wd0    (wd0),
        .i_wd1    (wd1),
        .o_done0  (done0),
        .o_done1  (done1),
        .o_rd0    (rd0),
        .o_rd1    (rd1),
        .o_err0   (err0),
        .o_err1   (err1),
        .o_busy   (busy),
        .o_mem_a  (mem_a),
        .o_mem_wd (mem_wd),
        .o_mem_we (mem_we),
        .i_mem_rd (mem_rd)
    );

    // memory stub: 256 words indexed by address bits [9:2], unwritten words read a fixed pattern
    logic [31:0] stub_mem [256];
    bit   [255:0] stub_wr;
    int          wr_count;

    function automatic logic [31:0] init_pat(input logic [7:0] i);
        return 32'hA5A5_0000 ^ {16'h0, i, i};
    endfunction

    always @(posedge clk) begin
        if (mem_we) begin
            stub_mem[mem_a[9:2]] <= mem_wd;
            stub_wr[mem_a[9:2]]  <= 1'b1;
            wr_count             <= wr_count + 1;
        end
    end

    always_comb begin
        mem_rd = init_pat(mem_a[9:2]);
        if (stub_wr[mem_a[9:2]]) mem_rd = stub_mem[mem_a[9:2]];
    end

    // transaction-level reference model
    logic [31:0] model_mem [256];
    logic [31:0] model_rd  [2];
    int          last_served;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;

    function automatic bit model_legal(input logic [31:0] a);
        bit in_window;
        in_window = (a % 4 == 0) && (a >= 32'h7FFF_FF00) && (a <= 32'h7FFF_FFFC);
`ifdef DMEM_ARB_RANGE_CHECK_EN
        return in_window;
`else
        return in_window | 1'b1;
`endif
    endfunction

    task automatic model_reset();
        last_served = 1;
        model_rd[0] = 32'h0;
        model_rd[1] = 32'h0;
    endtask

    task automatic model_apply(input int p, input bit we, input logic [31:0] a, input logic [31:0] wd,
                               output logic [31:0] rd, output bit err, output int wr);
        if (!model_legal(a)) begin
            rd = 32'h0; err = 1'b1; wr = 0;
        end else if (we) begin
            model_mem[a[9:2]] = wd;
            rd = model_rd[p]; err = 1'b0; wr = 1;
        end else begin
            rd = model_mem[a[9:2]]; err = 1'b0; wr = 0;
        end
        model_rd[p] = rd;
        last_served = p;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_done0"}, 32'(done0), 0);
        chk({tag, "_done1"}, 32'(done1), 0);
        chk({tag, "_err"},   32'(err0 | err1), 0);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_rd0"},   rd0, 0);
        chk({tag, "_rd1"},   rd1, 0);
        chk({tag, "_mem_a"}, mem_a, 0);
        chk({tag, "_mem_wd"}, mem_wd, 0);
        chk({tag, "_mem_we"}, 32'(mem_we), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        model_reset();
    endtask

    // raise one or both requests together and check order, latency, data, error and write count
    task automatic run_batch(input bit en0, input bit en1, input bit w0, input bit w1,
                             input logic [31:0] ad0, input logic [31:0] ad1,
                             input logic [31:0] d0, input logic [31:0] d1);
        bit          pwe [2];
        logic [31:0] pa  [2];
        logic [31:0] pwd [2];
        int first, second, nserve, served, start_wr, exp_wr, wr, p, exp_p;
        logic [31:0] exp_rd;
        bit exp_err;
        pwe[0] = w0; pwe[1] = w1; pa[0] = ad0; pa[1] = ad1; pwd[0] = d0; pwd[1] = d1;
        @(negedge clk);
        if (en0 && en1) first = 1 - last_served;
        else            first = en0 ? 0 : 1;
        second = 1 - first;
        nserve = int'(en0) + int'(en1);
        req0 = en0; we0 = w0; a0 = ad0; wd0 = d0;
        req1 = en1; we1 = w1; a1 = ad1; wd1 = d1;
        start_wr = wr_count;
        exp_wr = 0;
        served = 0;
        for (int c = 1; c <= 8 && served < nserve; c++) begin
            @(negedge clk);
            if (done0 || done1) begin
                chk("single_done", 32'(done0 & done1), 0);
                p = done1 ? 1 : 0;
                exp_p = (served == 0) ? first : second;
                chk("order", 32'(p), 32'(exp_p));
                chk("latency", 32'(c), (served == 0) ? 32'd2 : 32'd4);
                model_apply(p, pwe[p], pa[p], pwd[p], exp_rd, exp_err, wr);
                exp_wr += wr;
                chk(p ? "rd1" : "rd0", p ? rd1 : rd0, exp_rd);
                chk(p ? "err1" : "err0", 32'(p ? err1 : err0), 32'(exp_err));
                if (p == 1) req1 = 1'b0; else req0 = 1'b0;
                served++;
            end else begin
                chk("busy_access", 32'(busy), 1);
            end
        end
        chk("batch_served", 32'(served), 32'(nserve));
        chk("write_count", 32'(wr_count - start_wr), 32'(exp_wr));
        req0 = 1'b0; req1 = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0, 1, 2: return 32'h7FFF_FF00 + 32'($urandom_range(0, 63)) * 4;
            3:       return 32'h7FFF_FF00 + 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3));
            4:       return 32'h7FFF_FE00 + 32'($urandom_range(0, 63)) * 4;
            5:       return 32'h8000_0000 + 32'($urandom_range(0, 63)) * 4;
            6:       return 32'h7FFF_FF00;
            7:       return 32'h7FFF_FFFC;
            8:       return 32'h7FFF_FEFC;
            default: return 32'h0;
        endcase
    endfunction

    logic [31:0] exp_rd_s;
    bit          exp_err_s;
    int          wr_s;
    int          start_wr_s;

    initial begin
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        a0 = 32'h0; a1 = 32'h0; wd0 = 32'h0; wd1 = 32'h0;
        for (int i = 0; i < 256; i++) model_mem[i] = init_pat(8'(i));
        model_reset();
        repeat (3) @(negedge clk);
        chk_reset_outputs("por");
        rst = 1'b0;

        // write then read back through port 0
        run_batch(1, 0, 1, 0, 32'h7FFF_FF10, 32'h0, 32'h113, 32'h0);
        run_batch(1, 0, 0, 0, 32'h7FFF_FF10, 32'h0, 32'h0, 32'h0);

        // simultaneous requests right after reset, then another tie
        do_reset();
        run_batch(1, 1, 0, 0, 32'h7FFF_FF10, 32'h7FFF_FF14, 32'h0, 32'h0);
        run_batch(1, 1, 0, 1, 32'h7FFF_FF18, 32'h7FFF_FF18, 32'h0, 32'h5555_AAAA);

        // out-of-window and misaligned writes
        run_batch(0, 1, 0, 1, 32'h0, 32'h0, 32'h0, 32'h0001_869F);
        run_batch(1, 0, 1, 0, 32'h7FFF_FF11, 32'h0, 32'hDEAD_BEEF, 32'h0);

        // reset in the middle of a write to 0x7FFFFF20
        run_batch(1, 0, 1, 0, 32'h7FFF_FF20, 32'h0, 32'h1234_5678, 32'h0);
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; a0 = 32'h7FFF_FF20; wd0 = 32'hFFFF_0000;
        @(negedge clk);
        chk("rst_pre_busy", 32'(busy), 1);
        chk("rst_pre_we", 32'(mem_we), 1);
        start_wr_s = wr_count;
        rst = 1'b1;
        #1;
        chk("rst_we_gated", 32'(mem_we), 0);
        @(negedge clk);
        chk_reset_outputs("rst_abort");
        chk("rst_no_write", 32'(wr_count - start_wr_s), 0);
        rst = 1'b0;
        req0 = 1'b0;
        model_reset();
        run_batch(1, 0, 0, 0, 32'h7FFF_FF20, 32'h0, 32'h0, 32'h0);

        // port 0 streams; port 1 joins and is served next
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; a0 = 32'h7FFF_FF10;
        for (int c = 1; c <= 12; c++) begin
            bit e0, e1;
            @(negedge clk);
            e0 = (c == 2) || (c == 5) || (c == 8) || (c == 12);
            e1 = (c == 10);
            chk("stream_done0", 32'(done0), 32'(e0));
            chk("stream_done1", 32'(done1), 32'(e1));
            if (e0) begin
                model_apply(0, 1'b0, 32'h7FFF_FF10, 32'h0, exp_rd_s, exp_err_s, wr_s);
                chk("stream_rd0", rd0, exp_rd_s);
            end
            if (e1) begin
                model_apply(1, 1'b0, 32'h7FFF_FF24, 32'h0, exp_rd_s, exp_err_s, wr_s);
                chk("stream_rd1", rd1, exp_rd_s);
            end
            if (c == 8) begin
                req1 = 1'b1; we1 = 1'b0; a1 = 32'h7FFF_FF24;
            end
            if (c == 10) req1 = 1'b0;
            if (c == 12) req0 = 1'b0;
        end

        // randomized mix of single and simultaneous accesses
        for (int n = 0; n < 40; n++) begin
            int mode;
            mode = $urandom_range(0, 2);
            run_batch(mode != 1, mode != 0, 1'($urandom), 1'($urandom),
                      rand_addr(), rand_addr(), $urandom, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
